// File: rtl/m401_ctl_pkg.sv
// Shared types and constants for the M401 run/stop/step/burst controller.
// State encoding, command-priority encoding and the default counter width.
package m401_ctl_pkg;

  localparam int DEF_CNT_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_COUNT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_STOP  = 3'd1,
    CMD_STEP  = 3'd2,
    CMD_BURST = 3'd3,
    CMD_RUN   = 3'd4
  } cmd_e;

  // Collapse simultaneous requests to one command: stop > step > burst > run.
  function automatic cmd_e cmd_select(input logic stop, input logic step,
                                      input logic burst, input logic run);
    cmd_e c;
    if (stop) begin
      c = CMD_STOP;
    end else if (step) begin
      c = CMD_STEP;
    end else if (burst) begin
      c = CMD_BURST;
    end else if (run) begin
      c = CMD_RUN;
    end else begin
      c = CMD_NONE;
    end
    return c;
  endfunction

endpackage

// File: rtl/pulse_rise_det.sv
// Rising-edge detector for multi-cycle backplane pulses.
// The history flop resets high so a pulse already present at reset release is not reported.
module pulse_rise_det (
  input  logic clk,
  input  logic reset,
  input  logic tick_in,
  output logic tick_rise
);

  logic tick_q;
  logic tick_d;

  // Next history value is simply the current input level.
  always_comb begin
    tick_d = tick_in;
  end

  // History register.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q <= 1'b1;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign tick_rise = tick_in & ~tick_q;

endmodule

// File: rtl/m401_burst_ctl.sv
// Run/stop/step/burst controller gating the M401 variable clock through J2/K2.
// Optional watchdog enabled by defining M401_BURST_CTL_WATCHDOG_EN.
module m401_burst_ctl
  import m401_ctl_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int WDOG_CYCLES = 2000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_stop,
  input  logic             cmd_step,
  input  logic             cmd_burst,
  input  logic             cmd_run,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             tick_in,
  output logic             clk_inhibit,
  output logic             tick_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining,
  output logic             fault
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               clk_inhibit_q, clk_inhibit_d;
  logic               tick_out_q, tick_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               tick_rise;
  logic               accept;
  logic               cmd_en;
  cmd_e               cmd;

`ifdef M401_BURST_CTL_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0]  wdog_q, wdog_d;
  logic               fault_q, fault_d;

  assign cmd_en = ~fault_q;
  assign fault  = fault_q;
`else
  assign cmd_en = 1'b1;
  assign fault  = 1'b0;
`endif

  pulse_rise_det u_rise (
    .clk      (clk),
    .reset    (reset),
    .tick_in  (tick_in),
    .tick_rise(tick_rise)
  );

  // Next-state, remaining-count and output computation.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    accept      = tick_rise & (state_q != ST_IDLE);
    tick_out_d  = accept;
    if (cmd_en) begin
      cmd = cmd_select(cmd_stop, cmd_step, cmd_burst, cmd_run);
    end else begin
      cmd = CMD_NONE;
    end

    case (state_q)
      ST_IDLE: begin
        case (cmd)
          CMD_STEP: begin
            state_d     = ST_COUNT;
            remaining_d = {{(CNT_W-1){1'b0}}, 1'b1};
          end
          CMD_BURST: begin
            if (burst_len != {CNT_W{1'b0}}) begin
              state_d     = ST_COUNT;
              remaining_d = burst_len;
            end else begin
              done_d      = 1'b1;
            end
          end
          CMD_RUN: begin
            state_d = ST_RUN;
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
      ST_RUN: begin
        if (cmd == CMD_STOP) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_COUNT: begin
        // A stop coinciding with the final tick still yields a single done.
        if (cmd == CMD_STOP) begin
          state_d     = ST_IDLE;
          remaining_d = {CNT_W{1'b0}};
          done_d      = 1'b1;
        end else if (accept) begin
          if (remaining_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_COUNT;
          end
          remaining_d = remaining_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = ST_COUNT;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        remaining_d = {CNT_W{1'b0}};
      end
    endcase

`ifdef M401_BURST_CTL_WATCHDOG_EN
    fault_d = fault_q;
    if ((state_q == ST_IDLE) || accept) begin
      wdog_d = {WDOG_W{1'b0}};
    end else if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
      wdog_d      = {WDOG_W{1'b0}};
      state_d     = ST_IDLE;
      remaining_d = {CNT_W{1'b0}};
      done_d      = 1'b1;
      fault_d     = 1'b1;
    end else begin
      wdog_d = wdog_q + {{(WDOG_W-1){1'b0}}, 1'b1};
    end
`endif

    clk_inhibit_d = (state_d == ST_IDLE);
    busy_d        = (state_d != ST_IDLE);
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      remaining_q   <= {CNT_W{1'b0}};
      clk_inhibit_q <= 1'b1;
      tick_out_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      clk_inhibit_q <= clk_inhibit_d;
      tick_out_q    <= tick_out_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

`ifdef M401_BURST_CTL_WATCHDOG_EN
  // Watchdog counter and sticky fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_q  <= {WDOG_W{1'b0}};
      fault_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      fault_q <= fault_d;
    end
  end
`endif

  assign clk_inhibit = clk_inhibit_q;
  assign tick_out    = tick_out_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign remaining   = remaining_q;

endmodule

// File: tb/tb_m401_burst_ctl.sv
// Self-checking bench for m401_burst_ctl: directed scenarios plus random commands,
// every cycle compared against a ticks-owed reference model.
module tb_m401_burst_ctl;

  localparam int CNT_W = 12;
  localparam int WDOG  = 1000;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_stop, cmd_step, cmd_burst, cmd_run;
  logic [CNT_W-1:0] burst_len;
  logic             tick_in;
  logic             clk_inhibit, tick_out, busy, done, fault;
  logic [CNT_W-1:0] remaining;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: owed = 0 idle, -1 free-running, n>0 ticks still owed.
  int owed;
  bit m_prev, m_fault;
  int m_wd;
  bit e_inh, e_tick, e_busy, e_done, e_fault;
  int e_rem;

  int tick_per, tick_hi, tick_ph;
  int seen_ticks, seen_dones;

  m401_burst_ctl #(.CNT_W(CNT_W), .WDOG_CYCLES(WDOG)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_stop   (cmd_stop),
    .cmd_step   (cmd_step),
    .cmd_burst  (cmd_burst),
    .cmd_run    (cmd_run),
    .burst_len  (burst_len),
    .tick_in    (tick_in),
    .clk_inhibit(clk_inhibit),
    .tick_out   (tick_out),
    .busy       (busy),
    .done       (done),
    .remaining  (remaining),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_step();
    bit rise, acc, was_active;
    if (reset) begin
      owed = 0; m_prev = 1'b1; m_fault = 1'b0; m_wd = 0;
      e_tick = 1'b0; e_done = 1'b0;
    end else begin
      was_active = (owed != 0);
      rise   = tick_in && !m_prev;
      acc    = rise && was_active;
      e_tick = acc;
      e_done = 1'b0;
      if (!was_active) begin
        if (!m_fault && !cmd_stop) begin
          if (cmd_step) owed = 1;
          else if (cmd_burst) begin
            if (burst_len == 0) e_done = 1'b1;
            else owed = int'(burst_len);
          end
          else if (cmd_run) owed = -1;
        end
      end else if (cmd_stop) begin
        owed = 0; e_done = 1'b1;
      end else if (acc && owed > 0) begin
        owed--;
        if (owed == 0) e_done = 1'b1;
      end
`ifdef M401_BURST_CTL_WATCHDOG_EN
      if (!was_active || acc) begin
        m_wd = 0;
      end else begin
        m_wd++;
        if (m_wd == WDOG) begin
          owed = 0; e_done = 1'b1; m_fault = 1'b1; m_wd = 0;
        end
      end
`endif
      m_prev = tick_in;
    end
    e_rem   = (owed > 0) ? owed : 0;
    e_inh   = (owed == 0);
    e_busy  = (owed != 0);
    e_fault = m_fault;
  endtask

  task automatic step_cycle();
    model_step();
    @(posedge clk);
    #1;
    check_val("clk_inhibit", {31'd0, clk_inhibit}, {31'd0, e_inh});
    check_val("tick_out",    {31'd0, tick_out},    {31'd0, e_tick});
    check_val("busy",        {31'd0, busy},        {31'd0, e_busy});
    check_val("done",        {31'd0, done},        {31'd0, e_done});
    check_val("fault",       {31'd0, fault},       {31'd0, e_fault});
    check_val("remaining",   {20'd0, remaining},   e_rem);
    seen_ticks += int'(tick_out);
    seen_dones += int'(done);
    reset = 1'b0;
    cmd_stop = 1'b0; cmd_step = 1'b0; cmd_burst = 1'b0; cmd_run = 1'b0;
    if (tick_per == 0) begin
      tick_in = 1'b0;
    end else begin
      tick_ph = (tick_ph + 1) % tick_per;
      tick_in = (tick_ph < tick_hi);
    end
  endtask

  task automatic send(input bit st, input bit sp, input bit bu, input bit ru, input int len);
    cmd_stop = st; cmd_step = sp; cmd_burst = bu; cmd_run = ru;
    burst_len = CNT_W'(len);
    step_cycle();
  endtask

  task automatic do_reset();
    repeat (3) begin
      reset = 1'b1;
      step_cycle();
    end
  endtask

  task automatic drain(input int n);
    repeat (n) step_cycle();
  endtask

  task automatic set_ticks(input int per, input int hi);
    tick_per = per; tick_hi = hi; tick_ph = 0;
    tick_in = (per != 0) && (hi > 0);
  endtask

  initial begin
    bit found;
    int r, cnt;
    reset = 1'b1;
    cmd_stop = 1'b0; cmd_step = 1'b0; cmd_burst = 1'b0; cmd_run = 1'b0;
    burst_len = '0;
    seen_ticks = 0; seen_dones = 0;

    // Idle with the M401 pulsing; tick_in is high across reset release.
    set_ticks(834, 10);
    do_reset();
    seen_ticks = 0;
    drain(1700);
    check_val("idle_ticks", seen_ticks, 0);

    // Single step.
    set_ticks(20, 3);
    seen_ticks = 0; seen_dones = 0;
    send(1'b0, 1'b1, 1'b0, 1'b0, 0);
    drain(60);
    check_val("step_ticks", seen_ticks, 1);
    check_val("step_dones", seen_dones, 1);

    // Burst of five, then a zero-length burst.
    seen_ticks = 0; seen_dones = 0;
    send(1'b0, 1'b0, 1'b1, 1'b0, 5);
    drain(150);
    check_val("burst5_ticks", seen_ticks, 5);
    check_val("burst5_dones", seen_dones, 1);
    seen_ticks = 0; seen_dones = 0;
    send(1'b0, 1'b0, 1'b1, 1'b0, 0);
    check_val("burst0_done", {31'd0, done}, 1);
    check_val("burst0_inh", {31'd0, clk_inhibit}, 1);
    drain(40);
    check_val("burst0_ticks", seen_ticks, 0);

    // Free run for ten ticks, stop coincident with the eleventh rise.
    seen_ticks = 0; seen_dones = 0;
    send(1'b0, 1'b0, 1'b0, 1'b1, 0);
    cnt = 0;
    while (seen_ticks < 10 && cnt < 2000) begin
      step_cycle(); cnt++;
    end
    check_val("run_ten_ticks", seen_ticks, 10);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (tick_in && !m_prev) begin
        cmd_stop = 1'b1;
        found = 1'b1;
      end
      step_cycle();
    end
    check_val("stop_rise_found", {31'd0, found}, 1);
    drain(30);
    check_val("run_stop_ticks", seen_ticks, 11);
    check_val("run_stop_dones", seen_dones, 1);
    check_val("run_stop_busy", {31'd0, busy}, 0);

    // Step beats run when both arrive together.
    seen_ticks = 0; seen_dones = 0;
    send(1'b0, 1'b1, 1'b0, 1'b1, 0);
    drain(80);
    check_val("step_vs_run_ticks", seen_ticks, 1);
    check_val("step_vs_run_busy", {31'd0, busy}, 0);

    // A burst request during COUNT is ignored.
    seen_ticks = 0; seen_dones = 0;
    send(1'b0, 1'b0, 1'b1, 1'b0, 4);
    drain(3);
    send(1'b0, 1'b0, 1'b1, 1'b0, 9);
    drain(150);
    check_val("burst_ignored_ticks", seen_ticks, 4);
    check_val("burst_ignored_dones", seen_dones, 1);

    // Random commands, tick rates and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        tick_per = $urandom_range(4, 30);
        tick_hi  = $urandom_range(1, 3);
      end
      r = $urandom_range(0, 99);
      burst_len = CNT_W'($urandom_range(0, 6));
      if (r < 3) cmd_stop = 1'b1;
      else if (r < 6) cmd_step = 1'b1;
      else if (r < 9) cmd_burst = 1'b1;
      else if (r < 11) cmd_run = 1'b1;
      else if (r < 14) begin
        cmd_stop = 1'($urandom_range(0, 1)); cmd_step = 1'($urandom_range(0, 1));
        cmd_burst = 1'($urandom_range(0, 1)); cmd_run = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 999) == 0) reset = 1'b1;
      step_cycle();
    end

`ifdef M401_BURST_CTL_WATCHDOG_EN
    // Free run with no ticks trips the watchdog.
    set_ticks(0, 0);
    do_reset();
    seen_ticks = 0;
    send(1'b0, 1'b0, 1'b0, 1'b1, 0);
    cnt = 0;
    while (!done && cnt < 1200) begin
      step_cycle(); cnt++;
    end
    check_val("wdog_cycles", cnt, WDOG);
    check_val("wdog_fault", {31'd0, fault}, 1);
    set_ticks(20, 3);
    send(1'b0, 1'b1, 1'b0, 1'b0, 0);
    drain(60);
    check_val("wdog_step_ignored", seen_ticks, 0);
    check_val("wdog_busy", {31'd0, busy}, 0);
    do_reset();
    check_val("wdog_fault_cleared", {31'd0, fault}, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/m401_burst_ctl.md
# m401_burst_ctl

Run/stop/step/burst controller for the M401 variable clock. Gates the M401 counter through its J2/K2 enable pair, so the M401 free-runs, stops, emits exactly one tick, or emits exactly N ticks on command. It sits between front-panel and maintenance logic and the M401, and republishes each accepted tick as a one-cycle strobe for the rest of the machine.

## Interface
Parameters:
- CNT_W, 12: width of the burst length and of the remaining-tick counter.
- WDOG_CYCLES, 2000000: watchdog limit in clk cycles without a tick while gated on. It must exceed 100e6/FREQ of the driven M401.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  synchronous, active-high.
- cmd_stop  in  1  one-cycle stop request.
- cmd_step  in  1  one-cycle request for a single tick.
- cmd_burst  in  1  one-cycle request for burst_len ticks.
- cmd_run  in  1  one-cycle free-run request.
- burst_len  in  CNT_W  tick count, sampled with cmd_burst.
- tick_in  in  1  M401 D2 output; active-high, multi-cycle pulse.
- clk_inhibit  out  1  drives both M401 J2 and K2. 1 holds the M401 counter; 0 lets it run.
- tick_out  out  1  one-cycle strobe per accepted tick.
- busy  out  1  high in RUN or COUNT.
- done  out  1  one-cycle strobe on return to IDLE.
- remaining  out  CNT_W  ticks still owed in COUNT; 0 otherwise.
- fault  out  1  sticky watchdog fault.

## Operation
- Edge detect: tick_rise = tick_in & ~tick_q. tick_q resets to 1, so a tick_in that is already high when reset releases is not counted.
- A tick is accepted only when tick_rise is high and the state is RUN or COUNT. Rises seen in IDLE are ignored.
- States:
  - IDLE (clk_inhibit=1).
  - RUN (clk_inhibit=0, unbounded).
  - COUNT (clk_inhibit=0, bounded by remaining).
- Command priority when several are asserted together: stop > step > burst > run.
  - Only cmd_stop is honoured outside IDLE.
  - cmd_stop in IDLE is a no-op; it produces no done.
- Transitions from IDLE:
  - cmd_step → COUNT, remaining=1.
  - cmd_burst with burst_len≠0 → COUNT, remaining=burst_len.
  - cmd_burst with burst_len=0 → stays in IDLE, done pulses next cycle, no ticks.
  - cmd_run → RUN.
- In COUNT, each accepted tick decrements remaining. An accepted tick with remaining=1 → IDLE with done.
- cmd_stop in RUN or COUNT → IDLE next edge with done; remaining is cleared.
  - A tick_rise in the same cycle as cmd_stop is still accepted and produces tick_out.
  - In COUNT, if that tick makes remaining reach 0, exactly one done is produced.
- The M401 phase is frozen by inhibit, not reset. A partial period resumes on the next run/step.
- Reset values: IDLE, clk_inhibit=1, tick_out=0, busy=0, done=0, remaining=0, fault=0, tick_q=1. Reset asserted mid-burst abandons the burst without producing done.
- remaining never wraps: it is a decrement-only counter, guarded by the state.

## Timing
- All outputs are registered.
- Command sampled at edge k → state, clk_inhibit and busy change at edge k+1.
- Accepted tick at edge k → tick_out high for the cycle after edge k+1, and remaining updates at edge k+1.
- End of a burst: done, busy=0 and clk_inhibit=1 all take effect at the edge after the last accepted tick's rise. The M401 counter advances at most one extra count, so no second tick is possible before the next full period.
- Back-to-back: a new command is accepted in the cycle done is high. Minimum IDLE dwell is one cycle.

## Configuration
- Macro: M401_BURST_CTL_WATCHDOG_EN.
- Defined:
  - A counter clears on entry to RUN/COUNT and on every accepted tick.
  - Reaching WDOG_CYCLES in RUN/COUNT forces IDLE, sets fault (sticky until reset) and pulses done.
  - While fault=1, all commands are ignored.
- Undefined:
  - No counter is built and fault is tied to 0.
  - WDOG_CYCLES is unused.

## Structure
- Package m401_ctl_pkg holds:
  - the state typedef (IDLE, RUN, COUNT);
  - the command-priority encoding constants;
  - the default CNT_W.
- Sub-module: pulse_rise_det, which takes clk, reset, tick_in and outputs tick_rise, with tick_q resetting to 1. It is reusable for other backplane pulse inputs.

## Test plan
- Reset, then tick_in pulsing every 834 cycles with no command → clk_inhibit=1, no tick_out, busy=0.
- cmd_step → clk_inhibit=0 one cycle later; exactly 1 tick_out; done and clk_inhibit=1 one edge after that tick's rise; remaining 1→0.
- cmd_burst with burst_len=5 → 5 tick_out strobes, remaining counts 5,4,3,2,1,0, a single done; burst_len=0 → done next cycle and clk_inhibit stays 1.
- cmd_run, 10 ticks, then cmd_stop coincident with the 11th tick_rise → 11 tick_out, one done, IDLE.
- Simultaneous cmd_run and cmd_step in IDLE → step wins (1 tick then IDLE); cmd_burst during COUNT is ignored; tick_in high when reset releases → no tick_out.
- With M401_BURST_CTL_WATCHDOG_EN defined and WDOG_CYCLES=1000: cmd_run with tick_in held low → fault=1, done at cycle 1000, subsequent cmd_step ignored until reset.
